// File: rtl/id_hazard_ctrl_pkg.sv
// rtl/id_hazard_ctrl_pkg.sv - opcodes, FSM state type and decode helpers for the ID hazard controller
package id_hazard_ctrl_pkg;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_SUBI = 6'h03;
    localparam logic [5:0] OP_AND  = 6'h04;
    localparam logic [5:0] OP_ANDI = 6'h05;
    localparam logic [5:0] OP_OR   = 6'h06;
    localparam logic [5:0] OP_ORI  = 6'h07;
    localparam logic [5:0] OP_XOR  = 6'h08;
    localparam logic [5:0] OP_XORI = 6'h09;
    localparam logic [5:0] OP_SLT  = 6'h0A;
    localparam logic [5:0] OP_SLTI = 6'h0B;
    localparam logic [5:0] OP_LDW  = 6'h0C;
    localparam logic [5:0] OP_STW  = 6'h0D;
    localparam logic [5:0] OP_BZ   = 6'h0E;
    localparam logic [5:0] OP_BEQ  = 6'h0F;
    localparam logic [5:0] OP_JR   = 6'h10;
    localparam logic [5:0] OP_HALT = 6'h11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    function automatic logic is_rtype(input logic [5:0] op);
        return (op <= OP_SLT) && !op[0];
    endfunction

    function automatic logic is_itype(input logic [5:0] op);
        return ((op <= OP_SLTI) && op[0]) || (op == OP_LDW);
    endfunction

    // Destination register, 0 when the instruction writes nothing.
    function automatic logic [4:0] dst_of(input logic [31:0] inst);
        logic [5:0] op;
        op = inst[31:26];
        if (is_rtype(op))      return inst[15:11];
        else if (is_itype(op)) return inst[20:16];
        else                   return 5'd0;
    endfunction

    // One-hot OR of source registers; r0 is masked because it can never be pending.
    function automatic logic [31:0] src_mask(input logic [31:0] inst);
        logic [5:0]  op;
        logic [31:0] w_rs;
        logic [31:0] w_rt;
        logic [31:0] w_m;
        op   = inst[31:26];
        w_rs = 32'h1 << inst[25:21];
        w_rt = 32'h1 << inst[20:16];
        if (is_rtype(op) || op == OP_STW || op == OP_BEQ)
            w_m = w_rs | w_rt;
        else if (is_itype(op) || op == OP_BZ || op == OP_JR)
            w_m = w_rs;
        else
            w_m = 32'h0;
        return w_m & ~32'h1;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_scoreboard.sv
// rtl/id_hazard_ctrl_scoreboard.sv - per-register pending-write scoreboard with RAW hazard detect
module hazard_scoreboard
    import id_hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_set_en,
    input  logic [4:0]  i_set_addr,
    input  logic        i_clr_en,
    input  logic [4:0]  i_clr_addr,
    input  logic [31:0] i_src_mask,
    output logic        o_hazard,
    output logic        o_empty
);

    logic [31:0] r_pend;
    logic [31:0] w_set;
    logic [31:0] w_clr;

    assign w_set = i_set_en ? (32'h1 << i_set_addr) : 32'h0;
    assign w_clr = i_clr_en ? (32'h1 << i_clr_addr) : 32'h0;

    // Set is applied after clear so a same-cycle issue keeps the register pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_pend <= 32'h0;
        else
            r_pend <= ((r_pend & ~w_clr) | w_set) & ~32'h1;
    end

    // Hazard looks only at the registered bits: no write-back bypass.
    assign o_hazard = |(r_pend & i_src_mask);
    assign o_empty  = (r_pend == 32'h0);

endmodule

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - IF/ID issue control: RAW stalls, branch flush, HALT drain
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int BR_PENALTY = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_id,
    input  logic             inst_valid,
    input  logic             br_taken_ex,
    input  logic             wb_we,
    input  logic [4:0]       wb_addr,
    output logic             issue,
    output logic             pc_en,
    output logic             id_en,
    output logic             id_bubble,
    output logic             flush_if,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] FLUSH_INIT = 3'(BR_PENALTY - 1);

    state_t           r_state;
    logic [2:0]       r_flush_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_halted;

    logic [4:0]  w_dst;
    logic [31:0] w_src;
    logic        w_is_halt;
    logic        w_hazard;
    logic        w_empty;
    logic        w_run;
    logic        w_stall;
    logic        w_issue;

    assign w_dst     = dst_of(inst_id);
    assign w_src     = src_mask(inst_id);
    assign w_is_halt = (inst_id[31:26] == OP_HALT);

    assign w_run   = (r_state == ST_RUN);
    assign w_stall = w_run & inst_valid & w_hazard;
    // A taken branch kills the wrong-path instruction sitting in ID.
    assign w_issue = w_run & inst_valid & !w_hazard & !br_taken_ex;

    hazard_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .i_set_en   (w_issue && (w_dst != 5'd0)),
        .i_set_addr (w_dst),
        .i_clr_en   (wb_we),
        .i_clr_addr (wb_addr),
        .i_src_mask (w_src),
        .o_hazard   (w_hazard),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
            r_stall_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            if (w_stall && r_stall_cnt != {CNT_W{1'b1}})
                r_stall_cnt <= r_stall_cnt + 1'b1;
            case (r_state)
                ST_RUN: begin
                    if (br_taken_ex) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= FLUSH_INIT;
                    end else if (w_issue && w_is_halt) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_FLUSH: begin
                    if (br_taken_ex)
                        r_flush_cnt <= FLUSH_INIT;
                    else if (r_flush_cnt == 3'd0)
                        r_state <= ST_RUN;
                    else
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_HALTED;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    assign issue     = w_issue;
    assign pc_en     = (w_run & !(inst_valid & w_hazard)) | (r_state == ST_FLUSH);
    assign id_en     = pc_en;
    assign id_bubble = !w_issue;
    assign flush_if  = (r_state == ST_FLUSH);
    assign halted    = r_halted;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Scoreboard-based pipeline controller between the IF and ID stages of the five-stage core. It detects read-after-write hazards on the 32-entry register file and stalls issue until write-back clears them. It also flushes wrong-path instructions after a taken branch, and drains the pipe and parks the core on HALT. It drives the IF/ID enables and the ID→EX bubble select; it holds no datapath state.

## Interface
- BR_PENALTY, 2: flush cycles after `br_taken_ex` (1–7).
- CNT_W, 16: stall performance counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- inst_id  in  32  instruction in ID; opcode [31:26], rs [25:21], rt [20:16], rd [15:11]
- inst_valid  in  1  `inst_id` is a real instruction
- br_taken_ex  in  1  single-cycle pulse from EX: branch/JR taken
- wb_we  in  1  WB writes the register file
- wb_addr  in  5  WB destination register
- issue  out  1  ID instruction advances to EX this cycle
- pc_en  out  1  IF may advance PC
- id_en  out  1  IF/ID register may load
- id_bubble  out  1  ID→EX register loads a NOP (opcode 0, all fields 0)
- flush_if  out  1  clear IF/ID register
- halted  out  1  core parked
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

## Operation
Decode by opcode:
- R-type (0x00, 0x02, 0x04, 0x06, 0x08, 0x0A): sources rs and rt; destination rd.
- I-type ALU (odd 0x01–0x0B) and LDW 0x0C: source rs; destination rt.
- STW 0x0D and BEQ 0x0F: sources rs and rt; no destination.
- BZ 0x0E and JR 0x10: source rs; no destination.
- HALT 0x11 and undefined opcodes: no sources, no destination. Undefined opcodes issue as NOPs.

Scoreboard:
- `pend[31:0]`, one bit per register.
- `hazard` = any source register with its `pend` bit set. r0 is never pending.
- On `issue` with destination d≠0: set `pend[d]`.
- On `wb_we`: clear `pend[wb_addr]`.
- Same register set and cleared in the same cycle: set wins.
- No WB bypass: a source cleared this cycle stalls this cycle and issues the next.

FSM states: RUN, FLUSH, DRAIN, HALTED.
- RUN: `issue` = `inst_valid` & !`hazard`.
  - `br_taken_ex` → FLUSH, with `flush_cnt` = BR_PENALTY−1.
  - Issued HALT → DRAIN.
  - `br_taken_ex` has priority over everything in the same cycle, including a HALT in ID (the HALT is flushed).
- FLUSH: `issue`=0, `flush_if`=1, `id_bubble`=1. `flush_cnt` decrements; → RUN when it reaches 0.
- DRAIN: `issue`=0, `pc_en`=0, `id_bubble`=1. → HALTED when `pend`==0.
- HALTED: `halted`=1, `pc_en`=`id_en`=0, `id_bubble`=1. Stays until reset.

Output rules:
- `pc_en` = `id_en` = (state==RUN & !(`inst_valid` & `hazard`)) | state==FLUSH.
- `id_bubble` = !`issue`.
- `stall_cnt` increments when state==RUN & `inst_valid` & `hazard`; saturates at all-ones.

## Timing
- `hazard`, `issue`, `pc_en`, `id_en`, `id_bubble`, `flush_if` are combinational from the registered state and current inputs, with zero latency.
- `pend`, state, `flush_cnt`, `stall_cnt` update on rising clk.
- `halted` is registered: it asserts the cycle after `pend` reaches 0 in DRAIN.
- Dependent issue occurs at the earliest one cycle after the WB cycle that clears its source.
- Reset (async assert, any state, including mid-stall or mid-flush):
  - `pend`=0, state=RUN, `flush_cnt`=0, `stall_cnt`=0, `halted`=0.
  - Combinational outputs follow from RUN with no hazard: `pc_en`=`id_en`=1, `flush_if`=0.
- `br_taken_ex` arriving during FLUSH reloads `flush_cnt`. During DRAIN or HALTED it is ignored.

## Structure
- Shared package: opcode localparams (ADD..HALT), `state_t` enum, and functions `dst_of(inst)`, `src_mask(inst)` returning a 32-bit one-hot OR mask.
- Sub-module `hazard_scoreboard`: `pend` register, set/clear/priority logic, `hazard` and `empty` outputs.
- FSM and counters live in the top module.

## Test plan
- `add r3,r1,r2` issues, then `add r4,r3,r1` in ID → `issue`=0, `pc_en`=0, `stall_cnt` +1 per cycle. `wb_we`/`wb_addr`=3 → `issue`=1 on the next cycle.
- `addi r0,r1,5` issues, then `add r6,r0,r0` → no stall; `pend`==0.
- `br_taken_ex` pulse with BR_PENALTY=2 → `flush_if`=1 and `issue`=0 for exactly 2 cycles; `pend` unchanged; RUN on cycle 3.
- `pend[5]`=1, HALT issues → DRAIN with `pc_en`=0. `wb_we`/`wb_addr`=5 → `halted`=1 one cycle later; subsequent `inst_valid` is ignored.
- `wb_we`/`wb_addr`=7 in the same cycle as issue of `addi r7,r1,1` → `pend[7]` stays 1.
- Reset asserted mid-FLUSH with `stall_cnt`=9 → all outputs at reset values immediately; `stall_cnt`=0.
